// File: rtl/alu_sequencer.sv
// Instruction sequencer for a registered alu: handshakes one decoded instruction,
// drives the alu across its one-cycle latency, writes back the result and {CF,OF,SF,ZF}.
module alu_sequencer #(
  parameter  int WIDTH = 8,
  parameter  int REGS  = 4,
  localparam int AW    = (REGS > 1) ? $clog2(REGS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       op,
  input  logic [AW-1:0]    rd,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic [WIDTH-1:0] imm,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_en,
  output logic             alu_oe,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cf,
  input  logic             alu_of,
  output logic [3:0]       flags,
  output logic             done,
  output logic             err,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [3:0] OP_LDI = 4'b0001;

  typedef enum logic [1:0] {IDLE, EXEC, WB, RET} state_t;

  typedef struct packed {
    logic [3:0]       op;
    logic [AW-1:0]    rd;
    logic [AW-1:0]    rs1;
    logic [AW-1:0]    rs2;
    logic [WIDTH-1:0] imm;
  } instr_t;

  state_t                      state, nxt;
  instr_t                      ir;
  logic [REGS-1:0][WIDTH-1:0]  rf;
  logic                        wr_en;
  logic [WIDTH-1:0]            wr_data;
  logic                        flag_we;

  // alu ops occupy 0010..0111; anything with op[3] set is illegal
  function automatic logic is_alu(input logic [3:0] o);
    return !o[3] && (o[2] | o[1]);
  endfunction

  // ready is gated by rst_n so it stays low for the whole reset window
  assign instr_ready = (state == IDLE) && rst_n;
  assign dbg_data    = rf[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ir    <= '0;
      rf    <= '0;
      flags <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && instr_valid)
        ir <= '{op: op, rd: rd, rs1: rs1, rs2: rs2, imm: imm};
      if (wr_en)
        rf[ir.rd] <= wr_data;
      if (flag_we)
        flags <= {alu_cf, alu_of, alu_result[WIDTH-1], alu_result == '0};
    end
  end

  always_comb begin
    nxt        = state;
    alu_opcode = '0;
    alu_a      = '0;
    alu_b      = '0;
    alu_en     = 1'b0;
    alu_oe     = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    wr_en      = 1'b0;
    wr_data    = ir.imm;
    flag_we    = 1'b0;
    unique case (state)
      IDLE: begin
        if (instr_valid) begin
          if (is_alu(op))        nxt = EXEC;
          else if (op == OP_LDI) nxt = WB;
          else                   nxt = RET;
        end
      end
      EXEC: begin
        // operands are read here, before any write of this instruction lands
        alu_opcode = ir.op;
        alu_a      = rf[ir.rs1];
        alu_b      = rf[ir.rs2];
        alu_en     = 1'b1;
        nxt        = WB;
      end
      WB: begin
        if (is_alu(ir.op)) begin
          alu_oe  = 1'b1;
          wr_en   = 1'b1;
          wr_data = alu_result;
          flag_we = 1'b1;
        end else if (ir.op == OP_LDI) begin
          wr_en = 1'b1;
        end
        nxt = RET;
      end
      RET: begin
        done = 1'b1;
        err  = ir.op[3];
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: alu stub, instruction-level reference model with a per-cycle
// compare process, directed scenarios with literal expectations, then random traffic.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] op;
  logic [1:0] rd, rs1, rs2, dbg_addr;
  logic [7:0] imm;
  logic [3:0] alu_opcode;
  logic [7:0] alu_a, alu_b, alu_result, dbg_data;
  logic       alu_en, alu_oe, alu_cf, alu_of, done, err;
  logic [3:0] flags;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, en_cnt = 0;

  alu_sequencer #(.WIDTH(8), .REGS(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_en(alu_en), .alu_oe(alu_oe),
    .alu_result(alu_result), .alu_cf(alu_cf), .alu_of(alu_of),
    .flags(flags), .done(done), .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // alu behaviour: 2 ADD, 3 SUB (CF = borrow), 4 AND, 5 OR, 6 XOR, 7 SHL (CF = bit shifted out)
  function automatic logic [9:0] alu_fn(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (o)
      4'd2: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd3: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: begin r = {a[6:0], 1'b0}; c = a[7]; end
      default: r = '0;
    endcase
    return {c, v, r};
  endfunction

  // alu stub: registers on EN, drives its output only while OE
  logic [7:0] alu_q = '0;
  logic       cf_q = 1'b0, of_q = 1'b0;
  always @(posedge clk) if (alu_en) {cf_q, of_q, alu_q} <= alu_fn(alu_opcode, alu_a, alu_b);
  assign alu_result = alu_oe ? alu_q : 8'h00;
  assign alu_cf     = alu_oe & cf_q;
  assign alu_of     = alu_oe & of_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_regs [4];
  logic [3:0] m_flags;
  bit         p_act, p_alu, p_ldi, p_ill;
  int         p_start, p_ret;
  logic [3:0] p_op;
  logic [1:0] p_rd, p_rs1, p_rs2;
  logic [7:0] p_res;
  logic       p_cf, p_of;

  always @(negedge clk) begin
    if (!rst_n) begin
      foreach (m_regs[i]) m_regs[i] = 8'h00;
      m_flags = 4'h0;
      p_act   = 0;
      chk("rst_ready", instr_ready, 1'b0);
      chk("rst_done", {done, err}, 2'b00);
      chk("rst_alu", {alu_en, alu_oe, alu_opcode, alu_a, alu_b}, 22'h0);
      chk("rst_flags", flags, 4'h0);
      chk("rst_dbg", dbg_data, 8'h00);
    end else begin
      bit exp_ready, exp_done, exp_en, exp_oe;
      if (p_act && cyc == p_ret) begin
        if (p_alu) begin
          m_regs[p_rd] = p_res;
          m_flags = {p_cf, p_of, p_res[7], p_res == 8'h00};
        end else if (p_ldi) begin
          m_regs[p_rd] = p_res;
        end
      end
      exp_ready = !(p_act && cyc > p_start);
      exp_done  = p_act && cyc == p_ret;
      exp_en    = p_act && p_alu && cyc == p_start + 1;
      exp_oe    = p_act && p_alu && cyc == p_start + 2;
      chk("ready", instr_ready, exp_ready);
      chk("done", done, exp_done);
      chk("err", err, exp_done && p_ill);
      chk("alu_en", alu_en, exp_en);
      chk("alu_oe", alu_oe, exp_oe);
      chk("flags", flags, m_flags);
      chk("dbg_data", dbg_data, m_regs[dbg_addr]);
      if (exp_en) begin
        chk("alu_opcode", alu_opcode, p_op);
        chk("alu_a", alu_a, m_regs[p_rs1]);
        chk("alu_b", alu_b, m_regs[p_rs2]);
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (alu_en) en_cnt++;
      if (exp_done) p_act = 0;
      if (exp_ready && instr_valid) begin
        p_act = 1; p_start = cyc;
        p_op = op; p_rd = rd; p_rs1 = rs1; p_rs2 = rs2;
        p_alu = (op >= 4'd2 && op <= 4'd7);
        p_ldi = (op == 4'd1);
        p_ill = op[3];
        p_cf = 1'b0; p_of = 1'b0; p_res = imm;
        if (p_alu) {p_cf, p_of, p_res} = alu_fn(op, m_regs[rs1], m_regs[rs2]);
        p_ret = cyc + (p_alu ? 3 : p_ldi ? 2 : 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic scramble();
    op = 4'($urandom); rd = 2'($urandom); rs1 = 2'($urandom); rs2 = 2'($urandom); imm = 8'($urandom);
  endtask

  task automatic issue(input logic [3:0] o, input logic [1:0] d, input logic [1:0] s1,
                       input logic [1:0] s2, input logic [7:0] im);
    bit got;
    @(posedge clk); #1;
    instr_valid = 1'b1; op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (instr_ready) got = 1;
    end
    if (!got) chk("handshake_timeout", 0, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    scramble();
  endtask

  task automatic settle_peek(input logic [1:0] a);
    repeat (5) @(posedge clk);
    #1 dbg_addr = a;
    @(negedge clk);
  endtask

  int d0, e0, n0, dq[$];

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; dbg_addr = '0; scramble();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 0x7F + 0x01 signed-overflows to 0x80
    d0 = done_cnt;
    issue(4'd1, 2'd1, 2'd0, 2'd0, 8'h7F);
    issue(4'd1, 2'd2, 2'd0, 2'd0, 8'h01);
    issue(4'd2, 2'd3, 2'd1, 2'd2, 8'h00);
    settle_peek(2'd3);
    chk("add_r3", dbg_data, 8'h80);
    chk("add_r3_model", m_regs[3], 8'h80);
    chk("add_flags", flags, 4'b0110);
    chk("add_done_pulses", done_cnt - d0, 3);

    issue(4'd1, 2'd1, 2'd0, 2'd0, 8'h05);
    issue(4'd1, 2'd2, 2'd0, 2'd0, 8'h07);
    issue(4'd3, 2'd0, 2'd1, 2'd2, 8'h00);
    settle_peek(2'd0);
    chk("sub_r0", dbg_data, 8'hFE);
    chk("sub_flags", flags, 4'b1010);

    issue(4'd1, 2'd1, 2'd0, 2'd0, 8'hAA);
    n0 = en_cnt;
    issue(4'd6, 2'd1, 2'd1, 2'd1, 8'h00);
    settle_peek(2'd1);
    chk("xor_r1", dbg_data, 8'h00);
    chk("xor_flags", flags, 4'b0001);
    chk("xor_en_cycles", en_cnt - n0, 1);

    d0 = done_cnt; e0 = err_cnt; n0 = en_cnt;
    issue(4'b1010, 2'd0, 2'd1, 2'd2, 8'h33);
    settle_peek(2'd0);
    chk("ill_r0", dbg_data, 8'hFE);
    chk("ill_flags", flags, 4'b0001);
    chk("ill_done_err", {done_cnt - d0, err_cnt - e0}, {32'd1, 32'd1});
    chk("ill_no_en", en_cnt - n0, 0);

    // VALID held across three ADDs: retire every 4 cycles
    @(posedge clk); #1;
    instr_valid = 1'b1; op = 4'd2; rd = 2'd3; rs1 = 2'd3; rs2 = 2'd2;
    dq.delete();
    for (int i = 0; i < 40 && dq.size() < 3; i++) begin
      @(negedge clk);
      if (done) dq.push_back(cyc);
    end
    @(posedge clk); #1 instr_valid = 1'b0;
    chk("hold_retired", dq.size(), 3);
    if (dq.size() == 3) begin
      chk("hold_gap1", dq[1] - dq[0], 4);
      chk("hold_gap2", dq[2] - dq[1], 4);
    end

    // reset dropped during WB of ADD r2 = r1 + r1
    issue(4'd1, 2'd1, 2'd0, 2'd0, 8'h11);
    settle_peek(2'd2);
    d0 = done_cnt;
    @(posedge clk); #1;
    instr_valid = 1'b1; op = 4'd2; rd = 2'd2; rs1 = 2'd1; rs2 = 2'd1;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", instr_ready, 1'b1);
    chk("rst_mid_r2", dbg_data, 8'h00);
    chk("rst_mid_no_done", done_cnt - d0, 0);

    // random traffic
    for (int k = 0; k < 200; k++) begin
      logic [3:0] o;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1 dbg_addr = 2'($urandom);
      o = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(1, 7));
      issue(o, 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
    end
    repeat (6) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
